exec_controller: RTL and testbench
==================================

# exec_controller

Sequencing controller for the execute stage. It accepts one decoded operation at a time from decode. Single-cycle ALU operations go to the registered ALU (1-cycle result latency); mul/div operations go to a multi-cycle unit through a start/done handshake. The result is presented to writeback on a valid/ready port. It sits between decode and the executer/mul-div datapaths and owns flush handling and a mul/div watchdog.

## Interface
Parameters:
- XLEN, 32, operand/result width
- RD_W, 5, destination-register tag width
- MD_TIMEOUT, 64, max MD_WAIT cycles before abort; legal range 2..65535

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-high
- IN_VALID  in  1  decode offers an operation
- IN_READY  out  1  controller accepts this cycle
- IN_IS_MD  in  1  1 = mul/div op, 0 = ALU op
- IN_RD  in  RD_W  destination tag of offered op
- FLUSH  in  1  kill in-flight op (branch mispredict/trap)
- ALU_EN  out  1  launch ALU op this cycle (combinational)
- ALU_RESULT  in  XLEN  registered ALU output, valid the cycle after ALU_EN
- MD_START  out  1  one-cycle launch pulse to mul/div (combinational)
- MD_DONE  in  1  mul/div result valid (one-cycle pulse)
- MD_RESULT  in  XLEN  mul/div result, qualified by MD_DONE
- MD_ABORT  out  1  registered one-cycle pulse; mul/div discards current op
- OUT_VALID  out  1  result available to writeback
- OUT_READY  in  1  writeback accepts
- OUT_RESULT  out  XLEN  result, stable while OUT_VALID && !OUT_READY
- OUT_RD  out  RD_W  tag of result
- BUSY  out  1  state != IDLE
- ERR  out  1  sticky watchdog-expiry flag; cleared only by RST

## Operation
- States: IDLE, ALU_WAIT, MD_WAIT, RESP.
- IN_READY = !RST && !FLUSH && (IDLE || (RESP && OUT_READY)).
- accept = IN_VALID && IN_READY. On accept, IN_RD is latched.
  - ALU op: ALU_EN=1 that cycle, next state ALU_WAIT.
  - MD op: MD_START=1 that cycle, watchdog counter cleared, next state MD_WAIT.
- ALU_WAIT: capture ALU_RESULT into OUT_RESULT and the latched tag into OUT_RD, next state RESP. Always exactly one cycle.
- MD_WAIT: counter increments each cycle.
  - MD_DONE: capture MD_RESULT, next state RESP.
  - Counter reaches MD_TIMEOUT-1 without MD_DONE: MD_ABORT pulse, ERR set, next state IDLE, no result produced.
  - MD_DONE on the expiry cycle wins; no abort, no ERR.
- RESP: OUT_VALID=1.
  - OUT_READY with no accept: next state IDLE.
  - OUT_READY with a simultaneous accept: follow the accept rule (back-to-back issue).
  - Otherwise hold, with OUT_RESULT/OUT_RD unchanged.
- FLUSH, any state, takes priority over everything:
  - next state IDLE, OUT_VALID=0 next cycle, no accept that cycle;
  - an MD_DONE arriving in the same cycle is dropped;
  - if the state was MD_WAIT, MD_ABORT pulses next cycle.
  - FLUSH during RESP discards the pending result even if OUT_READY=1 that cycle; writeback must ignore it.
- MD_DONE outside MD_WAIT is ignored.

## Timing
- Reset values: state IDLE, OUT_VALID 0, OUT_RESULT 0, OUT_RD 0, MD_ABORT 0, ERR 0, counter 0. ALU_EN, MD_START and IN_READY are 0 while RST=1.
- RST mid-operation: same as FLUSH, except no MD_ABORT is generated; the mul/div unit is reset by the same RST.
- ALU op latency: accept at cycle N, OUT_VALID at N+2. Sustained throughput is 1 op / 2 cycles with OUT_READY tied high.
- MD op latency: accept at N, MD_DONE at N+k (k ≥ 1), OUT_VALID at N+k+1.
- MD_ABORT from watchdog: accept at N, no MD_DONE; MD_ABORT=1 and ERR=1 in cycle N+MD_TIMEOUT, state IDLE that same cycle.
- OUT_VALID, once high, stays high until the OUT_READY handshake or FLUSH/RST. No combinational path from OUT_READY to OUT_VALID/OUT_RESULT.

## Structure
- Shared package exec_pkg:
  - state enum exec_state_e {IDLE, ALU_WAIT, MD_WAIT, RESP};
  - XLEN/RD_W constants;
  - exec_req_t struct {is_md, rd}.
- One sub-module, md_watchdog: clear/enable/expire counter sized $clog2(MD_TIMEOUT), parameterised by MD_TIMEOUT.
- Next-state logic is a single always_comb; all state and output registers are in one always_ff.

## Test plan
- Reset, then an ALU op (rd=3), ALU_RESULT=32'h0000_00AA, OUT_READY=1: ALU_EN in cycle 0; OUT_VALID with result AA, OUT_RD=3 in cycle 2; then IDLE.
- Four back-to-back ALU ops with OUT_READY=1: one OUT_VALID every 2 cycles, results in order, IN_READY high in each RESP cycle.
- MD op with MD_DONE after 10 cycles (result 32'hDEAD_BEEF), OUT_READY low for 5 cycles: OUT_VALID holds a stable DEADBEEF for 5 cycles; handshake on the 6th; IN_READY low throughout the hold.
- MD op with MD_TIMEOUT=8 and no MD_DONE: MD_ABORT pulse and ERR=1 in cycle 8; no OUT_VALID; ERR stays set through later ops until RST.
- FLUSH in MD_WAIT with MD_DONE in the same cycle: no OUT_VALID, MD_ABORT the next cycle, IN_READY back the cycle after the flush.
- FLUSH in RESP with OUT_READY=1: result discarded, OUT_VALID=0 the next cycle; RST asserted mid-MD_WAIT returns all outputs to reset values without MD_ABORT.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the execute-stage controller: state encoding, widths and the
// decoded-request record latched on accept.
package exec_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ALU_WAIT = 2'd1,
    MD_WAIT  = 2'd2,
    RESP     = 2'd3
  } exec_state_e;

  typedef struct packed {
    logic            is_md;
    logic [RD_W-1:0] rd;
  } exec_req_t;

endpackage

// File: rtl/exec_controller_if.sv
// Decode, ALU, mul/div and writeback signals seen by the execute controller.
// master = controller side, slave = surrounding datapath / bench side.
interface exec_controller_if #(
  parameter int XLEN = exec_pkg::XLEN,
  parameter int RD_W = exec_pkg::RD_W
);

  logic            IN_VALID;
  logic            IN_READY;
  logic            IN_IS_MD;
  logic [RD_W-1:0] IN_RD;
  logic            FLUSH;
  logic            ALU_EN;
  logic [XLEN-1:0] ALU_RESULT;
  logic            MD_START;
  logic            MD_DONE;
  logic [XLEN-1:0] MD_RESULT;
  logic            MD_ABORT;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] OUT_RESULT;
  logic [RD_W-1:0] OUT_RD;
  logic            BUSY;
  logic            ERR;

  modport master (
    input  IN_VALID, IN_IS_MD, IN_RD, FLUSH, ALU_RESULT, MD_DONE, MD_RESULT, OUT_READY,
    output IN_READY, ALU_EN, MD_START, MD_ABORT, OUT_VALID, OUT_RESULT, OUT_RD, BUSY, ERR
  );

  modport slave (
    output IN_VALID, IN_IS_MD, IN_RD, FLUSH, ALU_RESULT, MD_DONE, MD_RESULT, OUT_READY,
    input  IN_READY, ALU_EN, MD_START, MD_ABORT, OUT_VALID, OUT_RESULT, OUT_RD, BUSY, ERR
  );

endinterface

// File: rtl/md_watchdog.sv
// Mul/div watchdog: counts cycles while enabled, expire is combinational and
// flags the last cycle (count MD_TIMEOUT-2) so the abort register fires at MD_TIMEOUT.
module md_watchdog #(
  parameter int MD_TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(MD_TIMEOUT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = enable && (cnt_q == CW'(MD_TIMEOUT - 2));

endmodule

// File: rtl/exec_controller.sv
// Execute-stage sequencer: ALU results out 2 cycles after accept, mul/div 1 cycle
// after MD_DONE; new work is only taken when idle or as the held result drains.
module exec_controller #(
  parameter int XLEN       = exec_pkg::XLEN,
  parameter int RD_W       = exec_pkg::RD_W,
  parameter int MD_TIMEOUT = 64
) (
  input logic              CLK,
  input logic              RST,
  exec_controller_if.master bus
);

  import exec_pkg::*;

  exec_state_e     state_q, state_d;
  exec_req_t       in_req;
  logic [RD_W-1:0] rd_q;
  logic [RD_W-1:0] out_rd_q;
  logic [XLEN-1:0] out_result_q;
  logic            md_abort_q, md_abort_d;
  logic            err_q, err_set;
  logic            in_ready, accept;
  logic            alu_en, md_start;
  logic            capture_alu, capture_md;
  logic            wd_clear, wd_en, wd_expire;

  assign in_req = exec_req_t'{is_md: bus.IN_IS_MD, rd: bus.IN_RD};
  assign wd_en  = (state_q == MD_WAIT);

  md_watchdog #(
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_md_watchdog (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    alu_en      = 1'b0;
    md_start    = 1'b0;
    wd_clear    = 1'b0;
    capture_alu = 1'b0;
    capture_md  = 1'b0;
    md_abort_d  = 1'b0;
    err_set     = 1'b0;
    in_ready    = !RST && !bus.FLUSH &&
                  ((state_q == IDLE) || ((state_q == RESP) && bus.OUT_READY));
    accept      = bus.IN_VALID && in_ready;

    if (bus.FLUSH) begin
      // Flush wins over done/expiry; the unit still has to be told to drop its op.
      state_d    = IDLE;
      md_abort_d = (state_q == MD_WAIT);
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        ALU_WAIT: begin
          capture_alu = 1'b1;
          state_d     = RESP;
        end
        MD_WAIT: begin
          if (bus.MD_DONE) begin
            capture_md = 1'b1;
            state_d    = RESP;
          end else if (wd_expire) begin
            md_abort_d = 1'b1;
            err_set    = 1'b1;
            state_d    = IDLE;
          end
        end
        RESP: begin
          if (bus.OUT_READY) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (accept) begin
        alu_en   = !in_req.is_md;
        md_start = in_req.is_md;
        wd_clear = in_req.is_md;
        state_d  = in_req.is_md ? MD_WAIT : ALU_WAIT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      rd_q         <= '0;
      out_rd_q     <= '0;
      out_result_q <= '0;
      md_abort_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      md_abort_q <= md_abort_d;
      if (err_set) begin
        err_q <= 1'b1;
      end
      if (accept) begin
        rd_q <= in_req.rd;
      end
      if (capture_alu) begin
        out_result_q <= bus.ALU_RESULT;
        out_rd_q     <= rd_q;
      end
      if (capture_md) begin
        out_result_q <= bus.MD_RESULT;
        out_rd_q     <= rd_q;
      end
    end
  end

  assign bus.IN_READY   = in_ready;
  assign bus.ALU_EN     = alu_en;
  assign bus.MD_START   = md_start;
  assign bus.MD_ABORT   = md_abort_q;
  assign bus.OUT_VALID  = (state_q == RESP);
  assign bus.OUT_RESULT = out_result_q;
  assign bus.OUT_RD     = out_rd_q;
  assign bus.BUSY       = (state_q != IDLE);
  assign bus.ERR        = err_q;

endmodule

// File: tb/tb_exec_controller.sv
// Self-checking bench for exec_controller: each scenario task drives a timeline and
// compares against cycle counts derived from the op latency rules.
module tb_exec_controller;

  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam int TMO  = 12;

  logic CLK;
  logic RST;
  int   total = 0;
  int   bad   = 0;

  exec_controller_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

  exec_controller #(
    .XLEN(XLEN), .RD_W(RD_W), .MD_TIMEOUT(TMO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    bus.IN_VALID   = 1'b0;
    bus.IN_IS_MD   = 1'b0;
    bus.IN_RD      = '0;
    bus.FLUSH      = 1'b0;
    bus.ALU_RESULT = $urandom;
    bus.MD_DONE    = 1'b0;
    bus.MD_RESULT  = $urandom;
    bus.OUT_READY  = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    quiet();
    bus.IN_VALID = 1'b1;
    bus.IN_IS_MD = 1'(($urandom_range(0, 1)));
    repeat (2) tick();
    @(negedge CLK);
    total++; if (bus.IN_READY !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0h exp=0", bus.IN_READY); end
    total++; if (bus.ALU_EN !== 1'b0) begin bad++; $display("FAIL rst_alu_en got=%0h exp=0", bus.ALU_EN); end
    total++; if (bus.MD_START !== 1'b0) begin bad++; $display("FAIL rst_md_start got=%0h exp=0", bus.MD_START); end
    tick();
    RST = 1'b0;
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0h exp=0", bus.OUT_VALID); end
    total++; if (bus.OUT_RESULT !== '0) begin bad++; $display("FAIL rst_out_result got=%0h exp=0", bus.OUT_RESULT); end
    total++; if (bus.OUT_RD !== '0) begin bad++; $display("FAIL rst_out_rd got=%0h exp=0", bus.OUT_RD); end
    total++; if (bus.MD_ABORT !== 1'b0) begin bad++; $display("FAIL rst_md_abort got=%0h exp=0", bus.MD_ABORT); end
    total++; if (bus.ERR !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h exp=0", bus.ERR); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", bus.BUSY); end
    total++; if (bus.IN_READY !== 1'b1) begin bad++; $display("FAIL rst_idle_ready got=%0h exp=1", bus.IN_READY); end
    tick();
  endtask

  task automatic test_alu_single();
    logic [XLEN-1:0] res;
    logic [RD_W-1:0] rd;
    res = 32'h0000_00AA;
    rd  = 5'd3;
    quiet();
    bus.IN_VALID = 1'b1;
    bus.IN_RD    = rd;
    @(negedge CLK);
    total++; if (bus.ALU_EN !== 1'b1) begin bad++; $display("FAIL alu1_en got=%0h exp=1", bus.ALU_EN); end
    total++; if (bus.MD_START !== 1'b0) begin bad++; $display("FAIL alu1_md_start got=%0h exp=0", bus.MD_START); end
    tick();
    quiet();
    bus.ALU_RESULT = res;
    @(negedge CLK);
    total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL alu1_c1_valid got=%0h exp=0", bus.OUT_VALID); end
    total++; if (bus.BUSY !== 1'b1) begin bad++; $display("FAIL alu1_c1_busy got=%0h exp=1", bus.BUSY); end
    tick();
    quiet();
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    total++; if (bus.OUT_VALID !== 1'b1) begin bad++; $display("FAIL alu1_c2_valid got=%0h exp=1", bus.OUT_VALID); end
    total++; if (bus.OUT_RESULT !== res) begin bad++; $display("FAIL alu1_result got=%0h exp=%0h", bus.OUT_RESULT, res); end
    total++; if (bus.OUT_RD !== rd) begin bad++; $display("FAIL alu1_rd got=%0h exp=%0h", bus.OUT_RD, rd); end
    tick();
    quiet();
    @(negedge CLK);
    total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL alu1_c3_valid got=%0h exp=0", bus.OUT_VALID); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL alu1_c3_busy got=%0h exp=0", bus.BUSY); end
    tick();
  endtask

  // Op i is accepted in cycle 2i and its result is presented in cycle 2i+2.
  task automatic test_back_to_back();
    logic [XLEN-1:0] res [4];
    logic [RD_W-1:0] rd  [4];
    for (int i = 0; i < 4; i++) begin
      res[i] = $urandom;
      rd[i]  = RD_W'($urandom_range(0, 31));
    end
    for (int c = 0; c <= 9; c++) begin
      int k;
      k = c / 2;
      quiet();
      bus.OUT_READY = 1'b1;
      if (c % 2 == 0 && k < 4) begin
        bus.IN_VALID = 1'b1;
        bus.IN_RD    = rd[k];
      end
      if (c % 2 == 1 && k < 4) bus.ALU_RESULT = res[k];
      @(negedge CLK);
      if (c % 2 == 0) begin
        total++; if (bus.IN_READY !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c=%0d got=%0h exp=1", c, bus.IN_READY); end
        total++; if (bus.ALU_EN !== (k < 4)) begin bad++; $display("FAIL b2b_alu_en c=%0d got=%0h exp=%0h", c, bus.ALU_EN, (k < 4)); end
        if (c >= 2) begin
          total++; if (bus.OUT_VALID !== 1'b1) begin bad++; $display("FAIL b2b_valid c=%0d got=%0h exp=1", c, bus.OUT_VALID); end
          total++; if (bus.OUT_RESULT !== res[k-1]) begin bad++; $display("FAIL b2b_result c=%0d got=%0h exp=%0h", c, bus.OUT_RESULT, res[k-1]); end
          total++; if (bus.OUT_RD !== rd[k-1]) begin bad++; $display("FAIL b2b_rd c=%0d got=%0h exp=%0h", c, bus.OUT_RD, rd[k-1]); end
        end
      end else begin
        total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL b2b_gap c=%0d got=%0h exp=0", c, bus.OUT_VALID); end
      end
      tick();
    end
  endtask

  task automatic test_md_hold();
    logic [RD_W-1:0] rd;
    rd = RD_W'($urandom_range(0, 31));
    quiet();
    bus.IN_VALID = 1'b1;
    bus.IN_IS_MD = 1'b1;
    bus.IN_RD    = rd;
    @(negedge CLK);
    total++; if (bus.MD_START !== 1'b1) begin bad++; $display("FAIL mdh_start got=%0h exp=1", bus.MD_START); end
    total++; if (bus.ALU_EN !== 1'b0) begin bad++; $display("FAIL mdh_alu_en got=%0h exp=0", bus.ALU_EN); end
    tick();
    for (int c = 1; c <= 16; c++) begin
      quiet();
      bus.IN_VALID  = (c != 16);
      bus.IN_RD     = RD_W'($urandom_range(0, 31));
      bus.MD_DONE   = (c == 10) || (c == 13);
      bus.MD_RESULT = (c == 10) ? 32'hDEAD_BEEF : $urandom;
      bus.OUT_READY = (c == 16);
      @(negedge CLK);
      total++; if (bus.OUT_VALID !== (c > 10)) begin bad++; $display("FAIL mdh_valid c=%0d got=%0h exp=%0h", c, bus.OUT_VALID, (c > 10)); end
      total++; if (bus.IN_READY !== (c == 16)) begin bad++; $display("FAIL mdh_in_ready c=%0d got=%0h exp=%0h", c, bus.IN_READY, (c == 16)); end
      total++; if (bus.ALU_EN !== 1'b0) begin bad++; $display("FAIL mdh_alu_en c=%0d got=%0h exp=0", c, bus.ALU_EN); end
      if (c > 10) begin
        total++; if (bus.OUT_RESULT !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mdh_result c=%0d got=%0h exp=deadbeef", c, bus.OUT_RESULT); end
        total++; if (bus.OUT_RD !== rd) begin bad++; $display("FAIL mdh_rd c=%0d got=%0h exp=%0h", c, bus.OUT_RD, rd); end
      end
      tick();
    end
    quiet();
    @(negedge CLK);
    total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL mdh_after_valid got=%0h exp=0", bus.OUT_VALID); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL mdh_after_busy got=%0h exp=0", bus.BUSY); end
    tick();
  endtask

  // Random mix: an op with completion delay k presents its result at cycle k+1
  // (ALU k=1), then holds for d stalled cycles before the handshake.
  task automatic test_random_ops(input int n);
    for (int it = 0; it < n; it++) begin
      logic            is_md;
      logic [RD_W-1:0] rd;
      logic [XLEN-1:0] res;
      int              k, d;
      is_md = 1'(($urandom_range(0, 1)));
      if (it == 0) is_md = 1'b1;
      rd  = RD_W'($urandom_range(0, 31));
      res = $urandom;
      k   = is_md ? int'($urandom_range(1, TMO - 1)) : 1;
      if (it == 0) k = TMO - 1;
      d   = $urandom_range(0, 3);
      quiet();
      bus.IN_VALID = 1'b1;
      bus.IN_IS_MD = is_md;
      bus.IN_RD    = rd;
      @(negedge CLK);
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL rnd_idle_valid it=%0d got=%0h exp=0", it, bus.OUT_VALID); end
      total++; if (bus.IN_READY !== 1'b1) begin bad++; $display("FAIL rnd_in_ready it=%0d got=%0h exp=1", it, bus.IN_READY); end
      total++; if (bus.MD_START !== is_md) begin bad++; $display("FAIL rnd_md_start it=%0d got=%0h exp=%0h", it, bus.MD_START, is_md); end
      total++; if (bus.ALU_EN !== !is_md) begin bad++; $display("FAIL rnd_alu_en it=%0d got=%0h exp=%0h", it, bus.ALU_EN, !is_md); end
      tick();
      for (int c = 1; c <= k; c++) begin
        quiet();
        if (is_md) begin
          bus.MD_DONE = (c == k);
          if (c == k) bus.MD_RESULT = res;
        end else begin
          bus.ALU_RESULT = res;
          bus.MD_DONE    = 1'(($urandom_range(0, 1)));
        end
        @(negedge CLK);
        total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL rnd_wait_valid it=%0d c=%0d got=%0h exp=0", it, c, bus.OUT_VALID); end
        total++; if (bus.MD_ABORT !== 1'b0) begin bad++; $display("FAIL rnd_wait_abort it=%0d c=%0d got=%0h exp=0", it, c, bus.MD_ABORT); end
        total++; if (bus.IN_READY !== 1'b0) begin bad++; $display("FAIL rnd_wait_ready it=%0d c=%0d got=%0h exp=0", it, c, bus.IN_READY); end
        tick();
      end
      for (int c = 0; c <= d; c++) begin
        quiet();
        bus.OUT_READY = (c == d);
        bus.MD_DONE   = 1'(($urandom_range(0, 1)));
        @(negedge CLK);
        total++; if (bus.OUT_VALID !== 1'b1) begin bad++; $display("FAIL rnd_valid it=%0d c=%0d got=%0h exp=1", it, c, bus.OUT_VALID); end
        total++; if (bus.OUT_RESULT !== res) begin bad++; $display("FAIL rnd_result it=%0d got=%0h exp=%0h", it, bus.OUT_RESULT, res); end
        total++; if (bus.OUT_RD !== rd) begin bad++; $display("FAIL rnd_rd it=%0d got=%0h exp=%0h", it, bus.OUT_RD, rd); end
        total++; if (bus.MD_ABORT !== 1'b0) begin bad++; $display("FAIL rnd_resp_abort it=%0d got=%0h exp=0", it, bus.MD_ABORT); end
        tick();
      end
    end
    quiet();
    @(negedge CLK);
    total++; if (bus.ERR !== 1'b0) begin bad++; $display("FAIL rnd_err got=%0h exp=0", bus.ERR); end
    tick();
  endtask

  task automatic test_watchdog();
    logic [XLEN-1:0] res;
    quiet();
    bus.IN_VALID = 1'b1;
    bus.IN_IS_MD = 1'b1;
    bus.IN_RD    = RD_W'($urandom_range(0, 31));
    tick();
    for (int c = 1; c <= TMO + 1; c++) begin
      quiet();
      @(negedge CLK);
      total++; if (bus.MD_ABORT !== (c == TMO)) begin bad++; $display("FAIL wd_abort c=%0d got=%0h exp=%0h", c, bus.MD_ABORT, (c == TMO)); end
      total++; if (bus.ERR !== (c >= TMO)) begin bad++; $display("FAIL wd_err c=%0d got=%0h exp=%0h", c, bus.ERR, (c >= TMO)); end
      total++; if (bus.BUSY !== (c < TMO)) begin bad++; $display("FAIL wd_busy c=%0d got=%0h exp=%0h", c, bus.BUSY, (c < TMO)); end
      total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL wd_valid c=%0d got=%0h exp=0", c, bus.OUT_VALID); end
      tick();
    end
    res = $urandom;
    quiet();
    bus.IN_VALID = 1'b1;
    tick();
    quiet();
    bus.ALU_RESULT = res;
    tick();
    quiet();
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    total++; if (bus.OUT_RESULT !== res) begin bad++; $display("FAIL wd_next_result got=%0h exp=%0h", bus.OUT_RESULT, res); end
    total++; if (bus.ERR !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%0h exp=1", bus.ERR); end
    tick();
  endtask

  task automatic test_flush_md();
    quiet();
    bus.IN_VALID = 1'b1;
    bus.IN_IS_MD = 1'b1;
    tick();
    quiet();
    repeat (3) tick();
    bus.FLUSH     = 1'b1;
    bus.MD_DONE   = 1'b1;
    bus.IN_VALID  = 1'b1;
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    total++; if (bus.IN_READY !== 1'b0) begin bad++; $display("FAIL flmd_in_ready got=%0h exp=0", bus.IN_READY); end
    total++; if (bus.MD_START !== 1'b0) begin bad++; $display("FAIL flmd_md_start got=%0h exp=0", bus.MD_START); end
    tick();
    quiet();
    @(negedge CLK);
    total++; if (bus.MD_ABORT !== 1'b1) begin bad++; $display("FAIL flmd_abort got=%0h exp=1", bus.MD_ABORT); end
    total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL flmd_valid got=%0h exp=0", bus.OUT_VALID); end
    total++; if (bus.IN_READY !== 1'b1) begin bad++; $display("FAIL flmd_ready_back got=%0h exp=1", bus.IN_READY); end
    tick();
    @(negedge CLK);
    total++; if (bus.MD_ABORT !== 1'b0) begin bad++; $display("FAIL flmd_abort_once got=%0h exp=0", bus.MD_ABORT); end
    total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL flmd_valid2 got=%0h exp=0", bus.OUT_VALID); end
    tick();
  endtask

  task automatic test_flush_resp();
    quiet();
    bus.IN_VALID = 1'b1;
    bus.IN_RD    = RD_W'($urandom_range(1, 31));
    tick();
    quiet();
    bus.ALU_RESULT = $urandom | 32'h1;
    tick();
    quiet();
    bus.FLUSH     = 1'b1;
    bus.OUT_READY = 1'b1;
    bus.IN_VALID  = 1'b1;
    @(negedge CLK);
    total++; if (bus.IN_READY !== 1'b0) begin bad++; $display("FAIL flr_in_ready got=%0h exp=0", bus.IN_READY); end
    tick();
    quiet();
    @(negedge CLK);
    total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL flr_valid got=%0h exp=0", bus.OUT_VALID); end
    total++; if (bus.MD_ABORT !== 1'b0) begin bad++; $display("FAIL flr_abort got=%0h exp=0", bus.MD_ABORT); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL flr_busy got=%0h exp=0", bus.BUSY); end
    tick();
  endtask

  task automatic test_rst_mid();
    quiet();
    bus.IN_VALID = 1'b1;
    bus.IN_IS_MD = 1'b1;
    tick();
    quiet();
    repeat (3) tick();
    RST = 1'b1;
    bus.IN_VALID = 1'b1;
    @(negedge CLK);
    total++; if (bus.IN_READY !== 1'b0) begin bad++; $display("FAIL rstm_in_ready got=%0h exp=0", bus.IN_READY); end
    tick();
    RST = 1'b0;
    quiet();
    @(negedge CLK);
    total++; if (bus.MD_ABORT !== 1'b0) begin bad++; $display("FAIL rstm_abort got=%0h exp=0", bus.MD_ABORT); end
    total++; if (bus.OUT_VALID !== 1'b0) begin bad++; $display("FAIL rstm_valid got=%0h exp=0", bus.OUT_VALID); end
    total++; if (bus.OUT_RESULT !== '0) begin bad++; $display("FAIL rstm_result got=%0h exp=0", bus.OUT_RESULT); end
    total++; if (bus.OUT_RD !== '0) begin bad++; $display("FAIL rstm_rd got=%0h exp=0", bus.OUT_RD); end
    total++; if (bus.ERR !== 1'b0) begin bad++; $display("FAIL rstm_err got=%0h exp=0", bus.ERR); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL rstm_busy got=%0h exp=0", bus.BUSY); end
    tick();
    @(negedge CLK);
    total++; if (bus.MD_ABORT !== 1'b0) begin bad++; $display("FAIL rstm_abort2 got=%0h exp=0", bus.MD_ABORT); end
    tick();
  endtask

  initial begin
    RST = 1'b1;
    quiet();
    test_reset();
    test_alu_single();
    test_back_to_back();
    test_md_hold();
    test_random_ops(20);
    test_watchdog();
    test_flush_md();
    test_flush_resp();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
